axi_lite_clint_timer: RTL and testbench
=======================================

// Module: axi_lite_clint_timer
// PURPOSE
//  AXI-lite slave on the MMIO bus holding the RISC-V machine timer (mtime, mtimecmp).
//  Produces TimerStruct::TimerPack time_out, consumed by the core top for mtime reads and timer interrupts.
//  Sits directly upstream of the core top.
//  Independent read and write channel FSMs; 64-bit data path; one outstanding transaction per channel.
// PARAMETERS
//  C_S_AXI_ADDR_WIDTH  64  AXI address width; only addr[15:0] is decoded.
//  C_S_AXI_DATA_WIDTH  64  AXI data width; fixed at 64, wstrb is 8 bits.
//  TICK_DIV            1   clk cycles per mtime increment; legal range >=1.
// PORTS
//  clk       in   1    system clock
//  rstn      in   1    asynchronous active-low reset
//  slave_ift AXI_ift.Slave  -  AW/W/B/AR/R AXI-lite channels from the MMIO master
//  time_out  out  TimerPack  {mtime[63:0], mtip}; both fields registered
//  msip      out  1    software interrupt pending; present only with CLINT_MSIP_EN
// BEHAVIOUR
//  Reset (rstn low, asynchronous): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, mtip=0, msip=0, prescale cnt=0.
//  Reset (rstn low, asynchronous): awready=wready=arready=0, bvalid=rvalid=0, write and read FSMs in IDLE.
//  Reset mid-transaction: the transaction is dropped with no response.
//  Counter: cnt counts 0..TICK_DIV-1. When cnt==TICK_DIV-1, cnt goes to 0 and mtime increments by 1.
//  Counter wrap: mtime 2^64-1 wraps to 0.
//  mtip <= (mtime >= mtimecmp), unsigned, evaluated on the current register values, so it lags one cycle.
//  Register map (offset=addr[15:0]):
//    0x4000 MTIMECMP  R/W
//    0xBFF8 MTIME     R/W
//    0x0000 MSIP      R/W, bit0 only (with CLINT_MSIP_EN)
//  Decode errors: addr[2:0]!=0 or an unmapped offset gives SLVERR (2'b10); reads return 0; writes are ignored.
//  Write FSM states: W_IDLE, W_WAIT_AW, W_WAIT_W, W_RESP.
//   W_IDLE: awready=wready=1.
//    Both handshake in the same cycle: go to W_RESP.
//    Only AW handshakes: latch addr, go to W_WAIT_W.
//    Only W handshakes: latch data+strb, go to W_WAIT_AW.
//   W_WAIT_W: wready=1 only. W_WAIT_AW: awready=1 only.
//   Entering W_RESP: the register update occurs on the cycle that completes AW+W, byte-merged with wstrb.
//    bvalid=1 and bresp are set in the same cycle.
//   W_RESP: holds bvalid until bready, then returns to W_IDLE.
//  Read FSM states: R_IDLE (arready=1) and R_DATA.
//   The AR handshake captures rdata and rresp from the current register values, and rvalid=1 is set the next cycle.
//   R_DATA holds rvalid/rdata stable until rready, then returns to R_IDLE; arready=0 while in R_DATA.
//  Same-cycle write vs. increment on MTIME: the bus write wins and no increment occurs that cycle.
//  Same-cycle write vs. increment on MTIMECMP: the new value is used for mtip in the following cycle.
//  Same-cycle read and write to one register: the read returns the pre-write value.
//  Partial wstrb write to MTIME: the unwritten bytes keep their pre-increment value.
// CONFIGURATION
//  CLINT_MSIP_EN defined: MSIP register at 0x0000 with R/W bit0. The msip port exists and is registered (reset 0).
//  CLINT_MSIP_EN undefined: no msip port, and offset 0x0000 decodes as unmapped (SLVERR).
// STRUCTURE
//  TimerStruct package holds:
//   TimerPack typedef
//   offset localparams: MTIME_OFF, MTIMECMP_OFF, MSIP_OFF
//   resp codes: RESP_OKAY=2'b00, RESP_SLVERR=2'b10
//   FSM enum typedefs
//  One sub-module, clint_reg_decode: combinational offset/alignment decode to {sel_mtime, sel_cmp, sel_msip, err}.
//   It is shared by the read and write paths.
//  Counter, prescaler and both FSMs live in this module.
// TESTING
//  Reset, then idle for 10 cycles with TICK_DIV=1 -> mtime==10 and mtip==0.
//  Write MTIMECMP=20 with strb 8'hFF, then wait -> mtip rises on the cycle after mtime reaches 20.
//   Then write MTIMECMP=all-ones -> mtip falls one cycle later.
//  Issue W three cycles before AW, with bready held low for 5 cycles -> a single update.
//   bvalid stays high for all 5 cycles and then drops after the handshake; bresp=OKAY.
//  Write MTIME=64'hFFFF_FFFF_FFFF_FFFE with TICK_DIV=1 -> reads later show a wrapped value.
//   The same-cycle write beats the increment: the value read one cycle after B equals FFFE+1.
//  Read 0x4004 and 0x1234, and write 0x1234 -> rresp/bresp=SLVERR and rdata=0.
//   No register changes; the bus does not stall.
//  With CLINT_MSIP_EN: write 1 to 0x0000 -> msip=1 and a read returns 1.
//   Without the macro, the same write -> SLVERR.

Source files
------------

// File: rtl/axi_lite_clint_timer_pkg.sv
// Shared types for the CLINT machine timer: timer output bundle, register offsets,
// AXI response codes, FSM state types and the byte-lane merge helper.
package TimerStruct;

  typedef struct packed {
    logic [63:0] mtime;
    logic        mtip;
  } TimerPack;

  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MSIP_OFF     = 16'h0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    WIdle,
    WWaitAw,
    WWaitW,
    WResp
  } wr_state_e;

  typedef enum logic {
    RIdle,
    RData
  } rd_state_e;

  function automatic logic [63:0] byte_merge(input logic [63:0] old_val,
                                             input logic [63:0] new_val,
                                             input logic [7:0]  strb);
    logic [63:0] res;
    for (int i = 0; i < 8; i++) begin
      res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_ift.sv
// AXI-lite channel bundle between the MMIO master and the CLINT timer slave.
interface AXI_ift #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport Slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport Master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_clint_timer_decode.sv
// Combinational CLINT offset decode, used once for the write path and once for the read path.
// The MSIP select only exists when CLINT_MSIP_EN is defined.
module clint_reg_decode
  import TimerStruct::*;
(
  input  logic [15:0] off_i,
  output logic        sel_mtime_o,
  output logic        sel_cmp_o,
  output logic        sel_msip_o,
  output logic        err_o
);

  logic aligned;

  always_comb begin
    aligned     = (off_i[2:0] == 3'b000);
    sel_mtime_o = aligned && (off_i == MTIME_OFF);
    sel_cmp_o   = aligned && (off_i == MTIMECMP_OFF);
`ifdef CLINT_MSIP_EN
    sel_msip_o  = aligned && (off_i == MSIP_OFF);
`else
    sel_msip_o  = 1'b0;
`endif
    err_o       = !(sel_mtime_o || sel_cmp_o || sel_msip_o);
  end

endmodule

// File: rtl/axi_lite_clint_timer.sv
// AXI-lite CLINT machine timer: prescaled mtime, mtimecmp, registered mtip and independent
// read/write channel FSMs. Defining CLINT_MSIP_EN adds the MSIP register and msip port.
module axi_lite_clint_timer
  import TimerStruct::*;
#(
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 64,
  parameter int unsigned C_S_AXI_DATA_WIDTH = 64,
  parameter int unsigned TICK_DIV           = 1
) (
  input  logic     clk,
  input  logic     rstn,
  AXI_ift.Slave    slave_ift,
  output TimerPack time_out
`ifdef CLINT_MSIP_EN
  ,
  output logic     msip
`endif
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;
  logic [63:0]     mtime_q, mtime_d;
  logic [63:0]     mtimecmp_q, mtimecmp_d;
  logic            mtip_q;

  wr_state_e   wst_q;
  logic        awready_q, wready_q, bvalid_q;
  logic [1:0]  bresp_q;
  logic [15:0] awaddr_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;

  rd_state_e   rst_q;
  logic        arready_q, rvalid_q;
  logic [63:0] rdata_q;
  logic [1:0]  rresp_q;

  logic        aw_hs, w_hs, ar_hs;
  logic        wr_fire;
  logic [15:0] wr_off;
  logic [63:0] wr_data;
  logic [7:0]  wr_strb;
  logic [1:0]  wr_resp;
  logic        wr_sel_mtime, wr_sel_cmp, wr_sel_msip, wr_err;
  logic        rd_sel_mtime, rd_sel_cmp, rd_sel_msip, rd_err;
  logic [63:0] rd_val;

  logic unused_addr;
  assign unused_addr = ^{slave_ift.awaddr[C_S_AXI_ADDR_WIDTH-1:16],
                         slave_ift.araddr[C_S_AXI_ADDR_WIDTH-1:16]};

  assign aw_hs = slave_ift.awvalid && awready_q;
  assign w_hs  = slave_ift.wvalid && wready_q;
  assign ar_hs = slave_ift.arvalid && arready_q;

  // The half of the write that arrived first comes from the latch, the other from the bus.
  always_comb begin
    case (wst_q)
      WIdle:   wr_fire = aw_hs && w_hs;
      WWaitW:  wr_fire = w_hs;
      WWaitAw: wr_fire = aw_hs;
      default: wr_fire = 1'b0;
    endcase
    wr_off  = (wst_q == WWaitW) ? awaddr_q : slave_ift.awaddr[15:0];
    wr_data = (wst_q == WWaitAw) ? wdata_q : slave_ift.wdata[C_S_AXI_DATA_WIDTH-1:0];
    wr_strb = (wst_q == WWaitAw) ? wstrb_q : slave_ift.wstrb;
    wr_resp = wr_err ? RESP_SLVERR : RESP_OKAY;
  end

  clint_reg_decode u_wr_decode (
    .off_i       (wr_off),
    .sel_mtime_o (wr_sel_mtime),
    .sel_cmp_o   (wr_sel_cmp),
    .sel_msip_o  (wr_sel_msip),
    .err_o       (wr_err)
  );

  clint_reg_decode u_rd_decode (
    .off_i       (slave_ift.araddr[15:0]),
    .sel_mtime_o (rd_sel_mtime),
    .sel_cmp_o   (rd_sel_cmp),
    .sel_msip_o  (rd_sel_msip),
    .err_o       (rd_err)
  );

  // A bus write to MTIME replaces the increment for that cycle.
  always_comb begin
    tick       = (cnt_q == CntW'(TICK_DIV - 1));
    cnt_d      = tick ? '0 : cnt_q + 1'b1;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    if (wr_fire && wr_sel_mtime) begin
      mtime_d = byte_merge(mtime_q, wr_data, wr_strb);
    end
    if (wr_fire && wr_sel_cmp) begin
      mtimecmp_d = byte_merge(mtimecmp_q, wr_data, wr_strb);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q      <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      mtip_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end

`ifdef CLINT_MSIP_EN
  logic msip_q, msip_d;

  always_comb begin
    msip_d = msip_q;
    if (wr_fire && wr_sel_msip && wr_strb[0]) begin
      msip_d = wr_data[0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      msip_q <= 1'b0;
    end else begin
      msip_q <= msip_d;
    end
  end

  assign msip = msip_q;
`else
  logic unused_msip;
  assign unused_msip = wr_sel_msip ^ rd_sel_msip;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wst_q     <= WIdle;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (wst_q)
        WIdle: begin
          if (aw_hs && w_hs) begin
            wst_q     <= WResp;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_resp;
          end else if (aw_hs) begin
            wst_q     <= WWaitW;
            awaddr_q  <= slave_ift.awaddr[15:0];
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
          end else if (w_hs) begin
            wst_q     <= WWaitAw;
            wdata_q   <= slave_ift.wdata[C_S_AXI_DATA_WIDTH-1:0];
            wstrb_q   <= slave_ift.wstrb;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
          end else begin
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        WWaitW: begin
          if (w_hs) begin
            wst_q    <= WResp;
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
            bresp_q  <= wr_resp;
          end
        end
        WWaitAw: begin
          if (aw_hs) begin
            wst_q     <= WResp;
            awready_q <= 1'b0;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_resp;
          end
        end
        WResp: begin
          if (slave_ift.bready) begin
            wst_q     <= WIdle;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wst_q <= WIdle;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    if (rd_sel_mtime) begin
      rd_val = mtime_q;
    end else if (rd_sel_cmp) begin
      rd_val = mtimecmp_q;
`ifdef CLINT_MSIP_EN
    end else if (rd_sel_msip) begin
      rd_val = {63'd0, msip_q};
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_q     <= RIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      case (rst_q)
        RIdle: begin
          if (ar_hs) begin
            rst_q     <= RData;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_val;
            rresp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            arready_q <= 1'b1;
          end
        end
        RData: begin
          if (slave_ift.rready) begin
            rst_q     <= RIdle;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: rst_q <= RIdle;
      endcase
    end
  end

  assign slave_ift.awready = awready_q;
  assign slave_ift.wready  = wready_q;
  assign slave_ift.bvalid  = bvalid_q;
  assign slave_ift.bresp   = bresp_q;
  assign slave_ift.arready = arready_q;
  assign slave_ift.rvalid  = rvalid_q;
  assign slave_ift.rdata   = rdata_q;
  assign slave_ift.rresp   = rresp_q;

  assign time_out = TimerPack'{mtime: mtime_q, mtip: mtip_q};

endmodule

// File: tb/tb_axi_lite_clint_timer.sv
// Bench for axi_lite_clint_timer: expected B/R responses are queued when a transaction is issued
// and compared when the DUT answers; timer behaviour is checked on time_out directly.
module tb_axi_lite_clint_timer;
  import TimerStruct::*;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    bit          chk;
  } rd_exp_t;

  logic     clk;
  logic     rstn;
  TimerPack time_out;
`ifdef CLINT_MSIP_EN
  logic     msip;
`endif

  int checks = 0;
  int errors = 0;

  logic [1:0] bq[$];
  rd_exp_t    rq[$];

  AXI_ift bus ();

  axi_lite_clint_timer #(
    .C_S_AXI_ADDR_WIDTH (64),
    .C_S_AXI_DATA_WIDTH (64),
    .TICK_DIV           (1)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .slave_ift (bus),
    .time_out  (time_out)
`ifdef CLINT_MSIP_EN
    ,
    .msip      (msip)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_b(output logic [63:0] b_mtime, output logic b_mtip);
    int n = 0;
    logic [1:0] exp;
    bus.bready = 1'b1;
    while (!bus.bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    exp = bq.pop_front();
    checks++;
    b_mtime = time_out.mtime;
    b_mtip  = time_out.mtip;
    if (!bus.bvalid) begin
      errors++;
      $display("FAIL b_timeout: bvalid=%0b required 1 within 50 cycles", bus.bvalid);
    end else if (bus.bresp !== exp) begin
      errors++;
      $display("FAIL bresp: got %b required %b", bus.bresp, exp);
    end
    @(negedge clk);
    bus.bready = 1'b0;
  endtask

  task automatic axi_write(input logic [63:0] addr, input logic [63:0] data,
                           input logic [7:0] strb, input logic [1:0] exp_resp,
                           output logic [63:0] b_mtime, output logic b_mtip);
    logic aw_done = 1'b0, w_done = 1'b0, aw_now, w_now;
    int n = 0;
    bq.push_back(exp_resp);
    @(negedge clk);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      aw_now = bus.awvalid && bus.awready;
      w_now  = bus.wvalid && bus.wready;
      @(negedge clk);
      if (aw_now) begin bus.awvalid = 1'b0; aw_done = 1'b1; end
      if (w_now) begin bus.wvalid = 1'b0; w_done = 1'b1; end
      n++;
    end
    if (!(aw_done && w_done)) begin
      checks++;
      errors++;
      $display("FAIL aw_w_timeout: aw_done=%0b w_done=%0b required 1 1", aw_done, w_done);
      bus.awvalid = 1'b0;
      bus.wvalid = 1'b0;
    end
    wait_b(b_mtime, b_mtip);
  endtask

  task automatic axi_read(input logic [63:0] addr, input logic [63:0] exp_data,
                          input logic [1:0] exp_resp, input bit chk, output logic [63:0] data);
    rd_exp_t e;
    int n = 0;
    rq.push_back('{data: exp_data, resp: exp_resp, chk: chk});
    @(negedge clk);
    bus.araddr = addr; bus.arvalid = 1'b1;
    while (!bus.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    n = 0;
    while (!bus.rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    e = rq.pop_front();
    data = bus.rdata;
    checks++;
    if (!bus.rvalid) begin
      errors++;
      $display("FAIL r_timeout addr=%h: rvalid=%0b required 1", addr, bus.rvalid);
    end else if (bus.rresp !== e.resp || (e.chk && bus.rdata !== e.data)) begin
      errors++;
      $display("FAIL read addr=%h: got resp %b data %h required resp %b data %h",
               addr, bus.rresp, bus.rdata, e.resp, e.data);
    end
    @(negedge clk);
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    bus.awvalid = 0; bus.wvalid = 0; bus.bready = 0; bus.arvalid = 0; bus.rready = 0;
    bus.awaddr = '0; bus.wdata = '0; bus.wstrb = '0; bus.araddr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (time_out.mtime !== 64'd0 || time_out.mtip !== 1'b0) begin
      errors++;
      $display("FAIL reset_timer: mtime=%h mtip=%b required 0 0", time_out.mtime, time_out.mtip);
    end
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_bus: aw/w/ar/b/r=%b required 00000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    rstn = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (time_out.mtime !== 64'd10 || time_out.mtip !== 1'b0) begin
      errors++;
      $display("FAIL idle_count: mtime=%0d mtip=%b required 10 0", time_out.mtime, time_out.mtip);
    end
  endtask

  task automatic test_mtip();
    logic [63:0] bm;
    logic bt;
    bit found = 0;
    axi_write(64'h4000, 64'd20, 8'hFF, RESP_OKAY, bm, bt);
    for (int i = 0; i < 60 && !found; i++) begin
      if (time_out.mtime == 64'd20) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found || time_out.mtip !== 1'b0) begin
      errors++;
      $display("FAIL mtip_at_20: found=%0b mtip=%b required 1 0", found, time_out.mtip);
    end
    @(negedge clk);
    checks++;
    if (time_out.mtip !== 1'b1 || time_out.mtime !== 64'd21) begin
      errors++;
      $display("FAIL mtip_rise: mtime=%0d mtip=%b required 21 1", time_out.mtime, time_out.mtip);
    end
    axi_write(64'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, RESP_OKAY, bm, bt);
    checks++;
    if (bt !== 1'b1) begin
      errors++;
      $display("FAIL mtip_lag: mtip=%b required 1", bt);
    end
    checks++;
    if (time_out.mtip !== 1'b0) begin
      errors++;
      $display("FAIL mtip_fall: mtip=%b required 0", time_out.mtip);
    end
  endtask

  task automatic test_w_before_aw();
    logic [63:0] bm, rd;
    logic bt;
    int n = 0;
    bq.push_back(RESP_OKAY);
    @(negedge clk);
    bus.bready = 1'b0;
    bus.wdata = 64'h0000_0000_AABB_CCDD; bus.wstrb = 8'h0F; bus.wvalid = 1'b1;
    while (!bus.wready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.wvalid = 1'b0;
    @(negedge clk);
    bus.awaddr = 64'h4000; bus.awvalid = 1'b1;
    n = 0;
    while (!bus.awready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.bvalid !== 1'b1) begin
        errors++;
        $display("FAIL bvalid_hold cycle %0d: bvalid=%b required 1", i, bus.bvalid);
      end
      @(negedge clk);
    end
    wait_b(bm, bt);
    checks++;
    if (bus.bvalid !== 1'b0) begin
      errors++;
      $display("FAIL bvalid_drop: bvalid=%b required 0", bus.bvalid);
    end
    axi_read(64'h4000, 64'hFFFF_FFFF_AABB_CCDD, RESP_OKAY, 1, rd);
  endtask

  task automatic test_back_to_back();
    logic [63:0] bm, rd;
    logic bt;
    fork
      axi_write(64'h4000, 64'h5555_6666_7777_8888, 8'hFF, RESP_OKAY, bm, bt);
      axi_read(64'h4000, 64'hFFFF_FFFF_AABB_CCDD, RESP_OKAY, 1, rd);
    join
    axi_read(64'h4000, 64'h5555_6666_7777_8888, RESP_OKAY, 1, rd);
  endtask

  task automatic test_decode_err();
    logic [63:0] bm, rd;
    logic bt;
    axi_read(64'h4004, 64'd0, RESP_SLVERR, 1, rd);
    axi_read(64'h1234, 64'd0, RESP_SLVERR, 1, rd);
    axi_write(64'h1234, 64'h0123_4567_89AB_CDEF, 8'hFF, RESP_SLVERR, bm, bt);
    axi_write(64'h4004, 64'h0123_4567_89AB_CDEF, 8'hFF, RESP_SLVERR, bm, bt);
    axi_read(64'h4000, 64'h5555_6666_7777_8888, RESP_OKAY, 1, rd);
  endtask

  task automatic test_wrap();
    logic [63:0] bm, rd;
    logic bt;
    axi_write(64'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, RESP_OKAY, bm, bt);
    checks++;
    if (bm !== 64'hFFFF_FFFF_FFFF_FFFE) begin
      errors++;
      $display("FAIL write_wins: mtime=%h required fffffffffffffffe", bm);
    end
    checks++;
    if (time_out.mtime !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL after_b: mtime=%h required ffffffffffffffff", time_out.mtime);
    end
    @(negedge clk);
    checks++;
    if (time_out.mtime !== 64'd0) begin
      errors++;
      $display("FAIL wrap: mtime=%h required 0", time_out.mtime);
    end
    axi_read(64'hBFF8, 64'd0, RESP_OKAY, 0, rd);
    checks++;
    if (!(rd > 64'd0 && rd < 64'd50)) begin
      errors++;
      $display("FAIL wrap_read: rdata=%h required small wrapped value below 50", rd);
    end
  endtask

  task automatic test_msip();
    logic [63:0] bm, rd;
    logic bt;
`ifdef CLINT_MSIP_EN
    axi_write(64'h0000, 64'd1, 8'hFF, RESP_OKAY, bm, bt);
    checks++;
    if (msip !== 1'b1) begin
      errors++;
      $display("FAIL msip_port: msip=%b required 1", msip);
    end
    axi_read(64'h0000, 64'd1, RESP_OKAY, 1, rd);
`else
    axi_write(64'h0000, 64'd1, 8'hFF, RESP_SLVERR, bm, bt);
    axi_read(64'h0000, 64'd0, RESP_SLVERR, 1, rd);
`endif
  endtask

  initial begin
    test_reset();
    test_mtip();
    test_w_before_aw();
    test_back_to_back();
    test_decode_err();
    test_wrap();
    test_msip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
